// File: rtl/ad7616_par_adc_model.sv
// Cycle-accurate model of the AD7616 parallel front end: conversion timing, busy,
// self-identifying sample words on the read bus and channel-select register writes.
module ad7616_par_adc_model #(
  parameter int unsigned CONV_CYCLES = 100,
  parameter logic [3:0]  DATA_TAG    = 4'hA
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        rx_cnvst,
  output logic        rx_busy,
  input  logic        rx_cs_n,
  input  logic        rx_rd_n,
  input  logic        rx_wr_n,
  input  logic [15:0] rx_db_o,
  input  logic        rx_db_t,
  output logic [15:0] rx_db_i,
  output logic [15:0] conv_count,
  output logic        err_protocol
);

  localparam logic [15:0] LOAD_VAL   = 16'(CONV_CYCLES - 1);
  localparam logic [5:0]  CHSEL_ADDR = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_cnvst_q;
  logic        r_cnvst_qq;
  logic        r_rd_n_q;
  logic        r_wr_n_q;
  logic [15:0] r_cnt;
  logic        r_busy;
  logic [15:0] r_conv_count;
  logic [2:0]  r_chsel_a;
  logic [2:0]  r_chsel_b;
  logic [15:0] r_word_a;
  logic [15:0] r_word_b;
  logic        r_rd_ptr;
  logic [1:0]  r_rd_cnt;
  logic [15:0] r_db_i;
  logic        r_err;

  logic        w_sel;
  logic        w_cnvst_rise;
  logic        w_rd_rise;
  logic        w_wr_rise;
  logic        w_conflict;
  logic        w_conv_done;
  logic        w_wr_act;
  logic        w_chsel_wr;
  logic        w_rd_drive;
  logic        w_rd_step;
  logic        w_err_set;
  logic        w_unused_db;

  function automatic logic [15:0] f_sample_word(input logic half, input logic [2:0] ch,
                                                input logic [7:0] cnt);
    return {DATA_TAG, half, ch, cnt};
  endfunction

  // cnvst is sampled once and then edge-detected, so busy rises one cycle after the sampled rise
  assign w_sel        = ~rx_cs_n;
  assign w_cnvst_rise = r_cnvst_q & ~r_cnvst_qq;
  assign w_conflict   = w_sel & ~rx_rd_n & ~rx_wr_n;
  assign w_rd_rise    = w_sel & rx_rd_n & ~r_rd_n_q & r_wr_n_q;
  assign w_wr_rise    = w_sel & rx_wr_n & ~r_wr_n_q & r_rd_n_q;
  assign w_conv_done  = (r_state == ST_CONVERT) && (r_cnt == 16'd0);
  assign w_wr_act     = w_wr_rise & ~rx_db_t & (r_state != ST_CONVERT);
  assign w_chsel_wr   = w_wr_act & rx_db_o[15] & (rx_db_o[14:9] == CHSEL_ADDR);
  assign w_rd_drive   = (r_state == ST_READY) & w_sel & ~rx_rd_n & rx_db_t & rx_wr_n;
  assign w_rd_step    = (r_state == ST_READY) & w_rd_rise;
  assign w_unused_db  = ^{rx_db_o[8:7], rx_db_o[3]};

  assign w_err_set = (w_cnvst_rise & (r_state == ST_CONVERT))
                   | (w_rd_rise & (r_state != ST_READY))
                   | (w_wr_rise & (r_state == ST_CONVERT))
                   | w_conflict
                   | (w_rd_step & (r_rd_cnt == 2'd2));

  // Input history for edge detection
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_cnvst_q  <= 1'b0;
      r_cnvst_qq <= 1'b0;
      r_rd_n_q   <= 1'b1;
      r_wr_n_q   <= 1'b1;
    end else begin
      r_cnvst_q  <= rx_cnvst;
      r_cnvst_qq <= r_cnvst_q;
      r_rd_n_q   <= rx_rd_n;
      r_wr_n_q   <= rx_wr_n;
    end
  end

  // State register
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a rise during CONVERT is ignored here and only flagged
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cnvst_rise) begin
          w_state_nxt = ST_CONVERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (w_conv_done) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_READY: begin
        if (w_cnvst_rise) begin
          w_state_nxt = ST_CONVERT;
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Conversion down-counter and busy, which follows the state being entered
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= 16'd0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_CONVERT);
      if ((r_state != ST_CONVERT) && (w_state_nxt == ST_CONVERT)) begin
        r_cnt <= LOAD_VAL;
      end else if ((r_state == ST_CONVERT) && (r_cnt != 16'd0)) begin
        r_cnt <= r_cnt - 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Sample words use the pre-increment count; the count advances on the same edge
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_conv_count <= 16'd0;
      r_word_a     <= 16'h0000;
      r_word_b     <= 16'h0000;
    end else if (w_conv_done) begin
      r_conv_count <= r_conv_count + 16'd1;
      r_word_a     <= f_sample_word(1'b0, r_chsel_a, r_conv_count[7:0]);
      r_word_b     <= f_sample_word(1'b1, r_chsel_b, r_conv_count[7:0]);
    end else begin
      r_conv_count <= r_conv_count;
      r_word_a     <= r_word_a;
      r_word_b     <= r_word_b;
    end
  end

  // Channel-select register
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_chsel_a <= 3'd0;
      r_chsel_b <= 3'd0;
    end else if (w_chsel_wr) begin
      r_chsel_a <= rx_db_o[2:0];
      r_chsel_b <= rx_db_o[6:4];
    end else begin
      r_chsel_a <= r_chsel_a;
      r_chsel_b <= r_chsel_b;
    end
  end

  // Read pointer alternates A/B; the read count saturates so every extra read is caught
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= 1'b0;
      r_rd_cnt <= 2'd0;
    end else if (w_conv_done) begin
      r_rd_ptr <= 1'b0;
      r_rd_cnt <= 2'd0;
    end else if (w_rd_step) begin
      r_rd_ptr <= ~r_rd_ptr;
      r_rd_cnt <= (r_rd_cnt == 2'd2) ? 2'd2 : (r_rd_cnt + 2'd1);
    end else begin
      r_rd_ptr <= r_rd_ptr;
      r_rd_cnt <= r_rd_cnt;
    end
  end

  // Read bus and sticky protocol error
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_db_i <= 16'h0000;
      r_err  <= 1'b0;
    end else begin
      r_db_i <= w_rd_drive ? (r_rd_ptr ? r_word_b : r_word_a) : 16'h0000;
      r_err  <= r_err | w_err_set;
    end
  end

  assign rx_busy      = r_busy;
  assign rx_db_i      = r_db_i;
  assign conv_count   = r_conv_count;
  assign err_protocol = r_err;

endmodule

// File: tb/tb_ad7616_par_adc_model.sv
// Scoreboard bench for ad7616_par_adc_model: stimulus tasks push expectations,
// independent monitors pop them on read-data and busy events.
module tb_ad7616_par_adc_model;

  localparam int C = 100;

  logic        sys_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_cnvst = 1'b0;
  logic        rx_cs_n = 1'b1;
  logic        rx_rd_n = 1'b1;
  logic        rx_wr_n = 1'b1;
  logic        rx_db_t = 1'b1;
  logic [15:0] rx_db_o = 16'h0000;
  logic        rx_busy;
  logic [15:0] rx_db_i;
  logic [15:0] conv_count;
  logic        err_protocol;

  ad7616_par_adc_model #(.CONV_CYCLES(C), .DATA_TAG(4'hA)) dut (
    .sys_clk(sys_clk), .resetn(resetn), .rx_cnvst(rx_cnvst), .rx_busy(rx_busy),
    .rx_cs_n(rx_cs_n), .rx_rd_n(rx_rd_n), .rx_wr_n(rx_wr_n), .rx_db_o(rx_db_o),
    .rx_db_t(rx_db_t), .rx_db_i(rx_db_i), .conv_count(conv_count),
    .err_protocol(err_protocol)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          t;
    logic [15:0] cnt;
  } conv_exp_t;

  conv_exp_t   conv_q[$];
  logic [15:0] rd_q[$];

  // reference model state
  int m_count, m_cha, m_chb, m_ptr, m_nreads;
  logic [15:0] m_wa, m_wb;
  bit m_ready, m_busy, m_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [15:0] mk_word(input int half, input int ch, input int cnt);
    return 16'(32'hA000 + half * 32'h800 + ch * 32'h100 + (cnt % 256));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic reset_release();
    tick(3);
    conv_q.delete();
    rd_q.delete();
    m_count = 0; m_cha = 0; m_chb = 0; m_ptr = 0; m_nreads = 0;
    m_wa = 16'h0; m_wb = 16'h0; m_ready = 0; m_busy = 0; m_err = 0;
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    reset_release();
  endtask

  task automatic start_conv();
    conv_exp_t e;
    rx_cnvst = 1'b1;
    m_wa = mk_word(0, m_cha, m_count);
    m_wb = mk_word(1, m_chb, m_count);
    m_count = m_count + 1;
    e.t = cyc + 1;
    e.cnt = 16'(m_count);
    conv_q.push_back(e);
    m_ready = 1; m_ptr = 0; m_nreads = 0; m_busy = 1;
    tick(1);
    rx_cnvst = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = C + 20;
    while (rx_busy === 1'b1 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) fail("busy_timeout");
    m_busy = 0;
    tick(1);
  endtask

  task automatic conv();
    start_conv();
    wait_idle();
  endtask

  task automatic rd();
    logic [15:0] e;
    if (m_busy || !m_ready) begin
      e = 16'h0000;
      m_err = 1;
    end else begin
      e = (m_ptr == 1) ? m_wb : m_wa;
      m_nreads++;
      if (m_nreads > 2) m_err = 1;
      m_ptr = 1 - m_ptr;
    end
    rd_q.push_back(e);
    rx_cs_n = 1'b0; rx_rd_n = 1'b0;
    tick(2);
    rx_rd_n = 1'b1;
    tick(1);
    rx_cs_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] d);
    if (m_busy) m_err = 1;
    else if ((d >> 9) == 16'h0043) begin
      m_cha = int'(d & 16'h7);
      m_chb = int'((d >> 4) & 16'h7);
    end
    rx_db_t = 1'b0; rx_db_o = d; rx_cs_n = 1'b0; rx_wr_n = 1'b0;
    tick(2);
    rx_wr_n = 1'b1;
    tick(1);
    rx_cs_n = 1'b1; rx_db_t = 1'b1;
  endtask

  // read-data monitor: compares on the second edge of a clean read strobe
  initial begin : mon_rd
    int hold;
    hold = 0;
    forever begin
      @(posedge sys_clk);
      if (resetn && !rx_cs_n && !rx_rd_n && rx_db_t && rx_wr_n) hold++;
      else hold = 0;
      if (hold == 2) begin
        #1;
        if (rd_q.size() == 0) fail("rd_unexpected");
        else check("rd_data", 32'(rx_db_i), 32'(rd_q.pop_front()));
      end
    end
  end

  // conversion monitor: busy rise/fall cycles and count after each conversion
  initial begin : mon_conv
    logic prev;
    conv_exp_t h;
    prev = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!resetn) begin
        prev = 1'b0;
      end else begin
        if (rx_busy && !prev) begin
          if (conv_q.size() == 0) fail("busy_unexpected");
          else check("busy_rise_cycle", cyc, conv_q[0].t + 1);
        end else if (!rx_busy && prev) begin
          if (conv_q.size() == 0) fail("busy_fall_unexpected");
          else begin
            h = conv_q.pop_front();
            check("busy_fall_cycle", cyc, h.t + 1 + C);
            check("conv_count_at_fall", 32'(conv_count), 32'(h.cnt));
          end
        end
        prev = rx_busy;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] d;
    tick(1);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_db_i", 32'(rx_db_i), 32'd0);
    check("rst_conv_count", 32'(conv_count), 32'd0);
    check("rst_err", 32'(err_protocol), 32'd0);
    reset_release();

    // single conversion
    conv();
    check("single_count", 32'(conv_count), 32'd1);
    check("single_err", 32'(err_protocol), 32'(m_err));

    // channel-select write then two reads, then a third
    do_reset();
    wr(16'h8650);
    conv();
    rd();
    rd();
    check("two_reads_err", 32'(err_protocol), 32'(m_err));
    rd();
    check("third_read_err", 32'(err_protocol), 32'(m_err));

    // extra cnvst pulse mid-conversion
    do_reset();
    start_conv();
    tick(8);
    rx_cnvst = 1'b1;
    tick(1);
    rx_cnvst = 1'b0;
    m_err = 1;
    wait_idle();
    check("retrig_count", 32'(conv_count), 32'd1);
    check("retrig_err", 32'(err_protocol), 32'(m_err));

    // reset mid-conversion
    do_reset();
    start_conv();
    tick(48);
    resetn = 1'b0;
    #1;
    check("busy_async_drop", 32'(rx_busy), 32'd0);
    reset_release();
    check("abort_count", 32'(conv_count), 32'd0);
    conv();
    rd();
    rd();

    // rise sampled on the busy-falling edge starts the next conversion
    start_conv();
    tick(C - 1);
    start_conv();
    wait_idle();
    rd();
    rd();
    check("b2b_count", 32'(conv_count), 32'(m_count));

    // write during conversion is discarded
    do_reset();
    start_conv();
    wr(16'h8677);
    wait_idle();
    rd();
    rd();
    check("wr_in_conv_err", 32'(err_protocol), 32'(m_err));

    // read while idle
    do_reset();
    rd();
    check("idle_read_err", 32'(err_protocol), 32'(m_err));

    // simultaneous read and write strobes
    do_reset();
    rx_cs_n = 1'b0; rx_rd_n = 1'b0; rx_wr_n = 1'b0;
    tick(2);
    check("conflict_db_i", 32'(rx_db_i), 32'd0);
    rx_rd_n = 1'b1; rx_wr_n = 1'b1;
    tick(1);
    rx_cs_n = 1'b1;
    m_err = 1;
    check("conflict_err", 32'(err_protocol), 32'(m_err));

    // 256 conversions with random channel writes: count byte wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d = (d & 16'h01FF) | 16'h8600;
        wr(d);
      end
      conv();
      rd();
      rd();
      tick($urandom_range(0, 3));
    end
    check("wrap_count", 32'(conv_count), 32'h0100);
    check("wrap_err", 32'(err_protocol), 32'd0);

    tick(5);
    check("rd_queue_drained", rd_q.size(), 0);
    check("conv_queue_drained", conv_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
